// File: rtl/wb_data_arbiter_if.sv
// Bus bundle for the two-master / one-slave pipelined Wishbone data arbiter.
// The master modport is the arbiter's view; the slave modport is the surrounding environment.
interface wb_data_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int SEL_WIDTH = DATA_WIDTH / 8;

    logic                  m0_cyc, m0_stb, m0_we;
    logic [ADDR_WIDTH-1:0] m0_addr;
    logic [DATA_WIDTH-1:0] m0_wdata;
    logic [SEL_WIDTH-1:0]  m0_sel;
    logic                  m0_stall, m0_ack;
    logic [DATA_WIDTH-1:0] m0_rdata;

    logic                  m1_cyc, m1_stb, m1_we;
    logic [ADDR_WIDTH-1:0] m1_addr;
    logic [DATA_WIDTH-1:0] m1_wdata;
    logic [SEL_WIDTH-1:0]  m1_sel;
    logic                  m1_stall, m1_ack;
    logic [DATA_WIDTH-1:0] m1_rdata;

    logic                  s_cyc, s_stb, s_we;
    logic [ADDR_WIDTH-1:0] s_addr;
    logic [DATA_WIDTH-1:0] s_wdata;
    logic [SEL_WIDTH-1:0]  s_sel;
    logic                  s_stall, s_ack;
    logic [DATA_WIDTH-1:0] s_rdata;

    modport master (
        input  m0_cyc, m0_stb, m0_we, m0_addr, m0_wdata, m0_sel,
        output m0_stall, m0_ack, m0_rdata,
        input  m1_cyc, m1_stb, m1_we, m1_addr, m1_wdata, m1_sel,
        output m1_stall, m1_ack, m1_rdata,
        output s_cyc, s_stb, s_we, s_addr, s_wdata, s_sel,
        input  s_stall, s_ack, s_rdata
    );

    modport slave (
        output m0_cyc, m0_stb, m0_we, m0_addr, m0_wdata, m0_sel,
        input  m0_stall, m0_ack, m0_rdata,
        output m1_cyc, m1_stb, m1_we, m1_addr, m1_wdata, m1_sel,
        input  m1_stall, m1_ack, m1_rdata,
        input  s_cyc, s_stb, s_we, s_addr, s_wdata, s_sel,
        output s_stall, s_ack, s_rdata
    );
endinterface

// File: rtl/wb_data_arbiter.sv
// Round-robin two-master Wishbone arbiter for the shared data memory port,
// with outstanding-request tracking and spurious-ack detection.
module wb_data_arbiter #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic               clk,
    input  logic               rst,
    wb_data_arbiter_if.master  bus,
    output logic [1:0]         grant,
    output logic               spurious_ack
);
    // state | meaning
    // IDLE  | no owner, slave cycle low, both masters stalled
    // G0    | master 0 owns the slave port
    // G1    | master 1 owns the slave port
    typedef enum logic [1:0] {IDLE = 2'b00, G0 = 2'b01, G1 = 2'b10} state_t;

    localparam int             CW      = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(MAX_OUTSTANDING);

    state_t         state, state_nxt;
    logic           lp, lp_nxt;
    logic [CW-1:0]  cnt, cnt_nxt;
    logic           spur_nxt;
    logic           g0, g1, sel_cyc, sel_stb, full, accept, ack_ok;

    assign g0      = (state == G0);
    assign g1      = (state == G1);
    assign sel_cyc = (g0 && bus.m0_cyc) || (g1 && bus.m1_cyc);
    assign sel_stb = (g0 && bus.m0_stb) || (g1 && bus.m1_stb);
    assign full    = (cnt == CNT_MAX);

    assign bus.s_cyc   = sel_cyc;
    assign bus.s_stb   = sel_stb && !full;
    assign bus.s_we    = g1 ? bus.m1_we    : (g0 && bus.m0_we);
    assign bus.s_addr  = g1 ? bus.m1_addr  : (g0 ? bus.m0_addr  : '0);
    assign bus.s_wdata = g1 ? bus.m1_wdata : (g0 ? bus.m0_wdata : '0);
    assign bus.s_sel   = g1 ? bus.m1_sel   : (g0 ? bus.m0_sel   : '0);

    assign accept = bus.s_stb && !bus.s_stall;
    // An ack only counts if something is in flight (or is being accepted right now).
    assign ack_ok = bus.s_ack && ((cnt != '0) || accept);

    assign bus.m0_stall = g0 ? (bus.s_stall || full) : 1'b1;
    assign bus.m1_stall = g1 ? (bus.s_stall || full) : 1'b1;
    assign bus.m0_ack   = g0 && ack_ok;
    assign bus.m1_ack   = g1 && ack_ok;
    assign bus.m0_rdata = g0 ? bus.s_rdata : '0;
    assign bus.m1_rdata = g1 ? bus.s_rdata : '0;

    assign grant = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            lp           <= 1'b1;
            cnt          <= '0;
            spurious_ack <= 1'b0;
        end else begin
            state        <= state_nxt;
            lp           <= lp_nxt;
            cnt          <= cnt_nxt;
            spurious_ack <= spur_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        lp_nxt    = lp;
        cnt_nxt   = cnt;
        spur_nxt  = bus.s_ack && (cnt == '0) && !accept;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (bus.m0_cyc && bus.m1_cyc) state_nxt = lp ? G0 : G1;
                else if (bus.m0_cyc)          state_nxt = G0;
                else if (bus.m1_cyc)          state_nxt = G1;
            end
            G0, G1: begin
                // Dropping cyc abandons anything still outstanding.
                if (!sel_cyc) begin
                    state_nxt = IDLE;
                    lp_nxt    = g1;
                    cnt_nxt   = '0;
                end else if (accept && !ack_ok) begin
                    cnt_nxt = cnt + 1'b1;
                end else if (!accept && ack_ok) begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule
